mem_ctrl: RTL

- Bus initiator between the CPU pipeline and the byte-wide unified memory.
- Takes word, half and byte requests from instruction fetch (read-only) and from the MEM stage (read/write).
- Serialises each request into single-byte accesses on the memory port, little-endian, one byte per cycle.
- Returns assembled data with a one-cycle done pulse. The memory is the responder on the other end of this interface.

---
 rtl/mem_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests into little-endian byte accesses on a byte-wide memory.
// Optional feature macro MEM_CTRL_SIGN_EXT_EN: when defined, signed byte/half loads are sign-extended.
module mem_ctrl #(
  parameter int READ_LAT = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

`ifdef MEM_CTRL_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        src_data_q, src_data_d;
  logic        signed_q, signed_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  cyc_q, cyc_d;
  logic [2:0]  cap_q, cap_d;
  logic        drv_q, drv_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [31:0] i_data_q, i_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [2:0]  nxt;
  logic        cap_en;
  logic [31:0] load_val;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'd0:    size_to_n = 3'd1;
      2'd1:    size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

  // drv marks a cycle that drives a read address; its delayed copy marks the matching capture when latency is 1
  always_comb begin
    state_d    = state_q;
    src_data_d = src_data_q;
    signed_d   = signed_q;
    n_d        = n_q;
    cyc_d      = cyc_q;
    cap_d      = cap_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    addr_d     = addr_q;
    rw_d       = 1'b0;
    wbyte_d    = 8'h00;
    i_data_d   = i_data_q;
    d_rdata_d  = d_rdata_q;
    load_val   = 32'h0;
    nxt        = cyc_q + 3'd1;
    drv_d      = (state_q == READ) && (cyc_q < n_q);
    cap_en     = (READ_LAT == 0) ? drv_d : drv_q;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          src_data_d = 1'b1;
          signed_d   = d_signed;
          n_d        = size_to_n(d_size);
          wdata_d    = d_wdata;
          addr_d     = d_addr;
          cyc_d      = 3'd0;
          cap_d      = 3'd0;
          buf_d      = 32'h0;
          if (d_we) begin
            state_d = WRITE;
            rw_d    = 1'b1;
            wbyte_d = d_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end else if (i_req) begin
          src_data_d = 1'b0;
          signed_d   = 1'b0;
          n_d        = 3'd4;
          addr_d     = i_addr;
          cyc_d      = 3'd0;
          cap_d      = 3'd0;
          buf_d      = 32'h0;
          state_d    = READ;
        end
      end
      WRITE: begin
        if (nxt < n_q) begin
          rw_d    = 1'b1;
          wbyte_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          addr_d  = addr_q + 32'd1;
          cyc_d   = nxt;
        end else begin
          state_d = DONE;
        end
      end
      READ: begin
        if (drv_d) begin
          cyc_d = nxt;
          if (nxt < n_q) addr_d = addr_q + 32'd1;
        end
        if (cap_en) begin
          buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_rdata;
          cap_d = cap_q + 3'd1;
          if (cap_q == n_q - 3'd1) begin
            state_d = DONE;
            case (n_q)
              3'd1:    load_val = {{24{SIGN_EXT & signed_q & buf_d[7]}}, buf_d[7:0]};
              3'd2:    load_val = {{16{SIGN_EXT & signed_q & buf_d[15]}}, buf_d[15:0]};
              default: load_val = buf_d;
            endcase
            if (src_data_q) d_rdata_d = load_val;
            else            i_data_d  = load_val;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      src_data_q <= 1'b0;
      signed_q   <= 1'b0;
      n_q        <= 3'd0;
      cyc_q      <= 3'd0;
      cap_q      <= 3'd0;
      drv_q      <= 1'b0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      addr_q     <= 32'h0;
      rw_q       <= 1'b0;
      wbyte_q    <= 8'h00;
      i_data_q   <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      src_data_q <= src_data_d;
      signed_q   <= signed_d;
      n_q        <= n_d;
      cyc_q      <= cyc_d;
      cap_q      <= cap_d;
      drv_q      <= drv_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wbyte_q    <= wbyte_d;
      i_data_q   <= i_data_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wbyte_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = (state_q == DONE) && !src_data_q;
  assign d_done    = (state_q == DONE) && src_data_q;
  assign busy      = (state_q != IDLE);

endmodule
